// File: rtl/prefix_adder_sequencer_if.sv
// Operand/result bus between a job source, the sequencer and the prefix_adder.
// The slave modport is the sequencer's view; master is the environment's view.
// Optional self-check ports exist only when PREFIX_SEQ_SELF_CHECK_EN is defined.
interface prefix_adder_sequencer_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [0:W-1] in_a;
  logic [0:W-1] in_b;
  logic         in_sub;
  logic [0:W-1] add_a;
  logic [0:W-1] add_b;
  logic [0:W-1] add_o;
  logic         out_valid;
  logic         out_ready;
  logic [0:W-1] out_result;
`ifdef PREFIX_SEQ_SELF_CHECK_EN
  logic         out_mismatch;
  logic [7:0]   mismatch_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, add_o, out_ready,
    output in_ready, add_a, add_b, out_valid, out_result, out_mismatch, mismatch_cnt
  );
  modport master (
    output in_valid, in_a, in_b, in_sub, add_o, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_result, out_mismatch, mismatch_cnt
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_sub, add_o, out_ready,
    output in_ready, add_a, add_b, out_valid, out_result
  );
  modport master (
    output in_valid, in_a, in_b, in_sub, add_o, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_result
  );
`endif
endinterface

// File: rtl/prefix_adder_sequencer.sv
// Initiator-side controller for a combinational prefix adder (o = a + b mod 2^W).
// Add jobs take one adder pass; subtract jobs take two (negate B, then add A).
// Vectors are [0:W-1] with bit 0 as MSB.
// Optional: define PREFIX_SEQ_SELF_CHECK_EN to compare each captured adder
// output against a behavioural sum and report out_mismatch / mismatch_cnt.
module prefix_adder_sequencer #(
  parameter int unsigned W      = 8,
  parameter int unsigned SETTLE = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  prefix_adder_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StNeg, StAdd, StHold} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic [0:W-1] a_lat_q;
  logic [0:W-1] add_a_q;
  logic [0:W-1] add_b_q;
  logic         out_valid_q;
  logic [0:W-1] out_result_q;

`ifdef PREFIX_SEQ_SELF_CHECK_EN
  logic         job_mm_q;
  logic         out_mm_q;
  logic [7:0]   mm_cnt_q;
  logic [0:W-1] sum_ref;
  logic         pass_mm;

  // Behavioural reference for whatever pair is currently on the adder
  always_comb begin
    sum_ref = add_a_q + add_b_q;
    pass_mm = (bus.add_o != sum_ref);
  end

  assign bus.out_mismatch = out_mm_q;
  assign bus.mismatch_cnt = mm_cnt_q;
`endif

  // Sequencer FSM with registered operand and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      a_lat_q      <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifdef PREFIX_SEQ_SELF_CHECK_EN
      job_mm_q     <= 1'b0;
      out_mm_q     <= 1'b0;
      mm_cnt_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            cnt_q <= '0;
`ifdef PREFIX_SEQ_SELF_CHECK_EN
            job_mm_q <= 1'b0;
`endif
            if (bus.in_sub) begin
              // Two's-complement negate of B on the adder: ~B + 1
              a_lat_q <= bus.in_a;
              add_a_q <= ~bus.in_b;
              add_b_q <= W'(1);
              state_q <= StNeg;
            end else begin
              add_a_q <= bus.in_a;
              add_b_q <= bus.in_b;
              state_q <= StAdd;
            end
          end
        end
        StNeg: begin
          if (cnt_q == SettleLast) begin
            add_a_q <= a_lat_q;
            add_b_q <= bus.add_o;
            cnt_q   <= '0;
            state_q <= StAdd;
`ifdef PREFIX_SEQ_SELF_CHECK_EN
            job_mm_q <= pass_mm;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StAdd: begin
          if (cnt_q == SettleLast) begin
            out_result_q <= bus.add_o;
            out_valid_q  <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StHold;
`ifdef PREFIX_SEQ_SELF_CHECK_EN
            out_mm_q <= job_mm_q | pass_mm;
            if ((job_mm_q | pass_mm) && (mm_cnt_q != 8'hFF)) begin
              mm_cnt_q <= mm_cnt_q + 8'd1;
            end
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
`ifdef PREFIX_SEQ_SELF_CHECK_EN
            out_mm_q <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;

endmodule

// File: tb/tb_prefix_adder_sequencer.sv
// Self-checking bench for prefix_adder_sequencer: directed vector table,
// randomized jobs against an arithmetic reference, backpressure and
// mid-operation reset sequences, and (when PREFIX_SEQ_SELF_CHECK_EN is defined)
// a faulty-adder scenario.
module tb_prefix_adder_sequencer;

  localparam int unsigned W      = 8;
  localparam int unsigned SETTLE = 2;
  localparam int          Mask   = (1 << W) - 1;

  logic clk;
  logic rst_n;
  logic fault_lsb;

  int n_tests;
  int n_fail;
  logic last_mm;

  prefix_adder_sequencer_if #(.W(W)) bus ();

  prefix_adder_sequencer #(.W(W), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Adder model; optional fault clears the LSB (bit W-1)
  always_comb begin
    bus.add_o = bus.add_a + bus.add_b;
    if (fault_lsb) bus.add_o[W-1] = 1'b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:W-1] a;
    logic [0:W-1] b;
    logic         sub;
    logic [0:W-1] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain modular arithmetic
  function automatic logic [0:W-1] model(input int a, input int b, input logic sub);
    int r;
    r = sub ? (a - b) : (a + b);
    return W'(r & Mask);
  endfunction

  // Run one job from IDLE with out_ready high; checks result, latency,
  // one-cycle valid pulse and operand hold afterwards
  task automatic do_job(input logic [0:W-1] a, input logic [0:W-1] b, input logic sub,
                        input logic [0:W-1] exp, input string name);
    int lat;
    logic [0:W-1] res;
    @(negedge clk);
    check({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_sub   = ~sub;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res     = bus.out_result;
`ifdef PREFIX_SEQ_SELF_CHECK_EN
    last_mm = bus.out_mismatch;
`else
    last_mm = 1'b0;
`endif
    check({name, ".result"}, 32'(res), 32'(exp));
    check({name, ".latency"}, 32'(lat), sub ? 32'(2 * SETTLE) : 32'(SETTLE));
    @(posedge clk);
    #1;
    check({name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({name, ".hold_a"}, 32'(bus.add_a), 32'(a));
    check({name, ".hold_b"}, 32'(bus.add_b), sub ? 32'((-int'(b)) & Mask) : 32'(b));
  endtask

  initial begin
    logic [0:W-1] ra, rb, held;
    logic         rs;
    int           seen;
    n_tests   = 0;
    n_fail    = 0;
    last_mm   = 1'b0;
    fault_lsb = 1'b0;

    vecs[0] = '{a: 8'd0,   b: 8'd65,  sub: 1'b0, exp: 8'd65};
    vecs[1] = '{a: 8'd100, b: 8'd24,  sub: 1'b0, exp: 8'd124};
    vecs[2] = '{a: 8'h55,  b: 8'hAA,  sub: 1'b0, exp: 8'hFF};
    vecs[3] = '{a: 8'hFF,  b: 8'h01,  sub: 1'b0, exp: 8'h00};
    vecs[4] = '{a: 8'd100, b: 8'd24,  sub: 1'b1, exp: 8'd76};
    vecs[5] = '{a: 8'd0,   b: 8'd1,   sub: 1'b1, exp: 8'hFF};
    vecs[6] = '{a: 8'h80,  b: 8'h80,  sub: 1'b1, exp: 8'h00};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.out_result", 32'(bus.out_result), 32'd0);
    check("reset.add_a", 32'(bus.add_a), 32'd0);
    check("reset.add_b", 32'(bus.add_b), 32'd0);
`ifdef PREFIX_SEQ_SELF_CHECK_EN
    check("reset.mismatch_cnt", 32'(bus.mismatch_cnt), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_job(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Randomized jobs against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, Mask));
      rb = W'($urandom_range(0, Mask));
      rs = 1'($urandom_range(0, 1));
      do_job(ra, rb, rs, model(int'(ra), int'(rb), rs), $sformatf("rnd%0d", i));
    end

    // Backpressure: hold result for 5 cycles while a new job waits
    bus.out_ready = 1'b0;
    do_job_start(8'd40, 8'd2, 1'b0);
    seen = 0;
    while (!bus.out_valid && seen < 50) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check("bp.result", 32'(bus.out_result), 32'd42);
    held = bus.out_result;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd9;
    bus.in_b     = 8'd9;
    bus.in_sub   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp.valid%0d", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp.held%0d", c), 32'(bus.out_result), 32'(held));
      check($sformatf("bp.in_ready%0d", c), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.release_valid", 32'(bus.out_valid), 32'd0);
    check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp.next_accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    seen = 0;
    while (!bus.out_valid && seen < 50) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check("bp.next_result", 32'(bus.out_result), 32'd18);
    check("bp.next_latency", 32'(seen), 32'(SETTLE));
    @(posedge clk);
    #1;

    // Reset during NEG of a subtract
    do_job_start(8'd50, 8'd7, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_result", 32'(bus.out_result), 32'd0);
    check("rst.add_a", 32'(bus.add_a), 32'd0);
    check("rst.add_b", 32'(bus.add_b), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("rst.no_output", 32'(seen), 32'd0);
    do_job(8'd3, 8'd4, 1'b0, 8'd7, "rst.after");

`ifdef PREFIX_SEQ_SELF_CHECK_EN
    fault_lsb = 1'b1;
    do_job(8'd1, 8'd0, 1'b0, 8'd0, "sc.fault");
    check("sc.fault_mm", 32'(last_mm), 32'd1);
    check("sc.fault_cnt", 32'(bus.mismatch_cnt), 32'd1);
    do_job(8'd2, 8'd2, 1'b0, 8'd4, "sc.good");
    check("sc.good_mm", 32'(last_mm), 32'd0);
    check("sc.good_cnt", 32'(bus.mismatch_cnt), 32'd1);
    fault_lsb = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Offer a job from IDLE and return just after its accept edge
  task automatic do_job_start(input logic [0:W-1] a, input logic [0:W-1] b, input logic sub);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

endmodule

// File: doc/prefix_adder_sequencer.md
Name: prefix_adder_sequencer

Overview:
- Initiator-side controller for the combinational prefix_adder, which takes operand buses a, b and returns sum o.
- Accepts operand jobs over a valid/ready input port and drives the adder's operand buses.
- Waits a fixed settle time, then captures the adder output and returns the result over a valid/ready output port.
- Supports add, plus subtract implemented as two adder passes (two's-complement negate, then add), so the adder needs no carry-in.

Parameters:
- W, 8, operand and result width; all vectors indexed [0:W-1], bit 0 = MSB.
- SETTLE, 2, cycles each operand pair is held on the adder before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  job offered.
- in_ready  output  1  sequencer can accept a job; high only in IDLE.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- add_a  output  W  drives prefix_adder a.
- add_b  output  W  drives prefix_adder b.
- add_o  input  W  prefix_adder o, sum mod 2^W.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  W  captured result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, add_a=0, add_b=0, out_valid=0, out_result=0, settle counter=0, latched A=0. in_ready=1 after reset (decoded from state).

States:
- IDLE, NEG, ADD, HOLD.

IDLE:
- in_ready=1.
- A job is accepted on an edge with in_valid=1.
- Add job (in_sub=0): load add_a=in_a, add_b=in_b, cnt=0, go ADD.
- Subtract job (in_sub=1): latch in_a internally, load add_a=~in_b, add_b=1, cnt=0, go NEG.

NEG:
- Each edge increments cnt.
- On the edge where cnt==SETTLE-1: load add_a=latched A, add_b=add_o (the negated B), cnt=0, go ADD.

ADD:
- Each edge increments cnt.
- On the edge where cnt==SETTLE-1: out_result<=add_o, out_valid<=1, go HOLD.

HOLD:
- out_valid=1. out_result is stable until the handshake completes.
- On an edge with out_ready=1: out_valid<=0, go IDLE.
- A new job cannot be accepted on the same edge, because in_ready=0 in HOLD.

Latency:
- Add: out_valid rises SETTLE edges after the accept edge.
- Subtract: out_valid rises 2*SETTLE edges after the accept edge.
- Minimum accept-to-accept spacing with out_ready tied high: SETTLE+2 cycles for add, 2*SETTLE+2 for subtract.

Arithmetic:
- All results are mod 2^W. Carry and borrow out are discarded.
- Negating 0 yields 0. Negating 2^(W-1) yields 2^(W-1).

Operand hold:
- add_a and add_b hold their last driven values through HOLD and IDLE until the next accept.

Input handshake:
- in_valid deasserting while in_ready=0 has no effect.
- in_a, in_b and in_sub are sampled only on the accept edge.

Reset mid-operation:
- Asserting rst_n low in any state immediately forces all reset values. The in-flight job is discarded with no output.

Optional Feature:
- Macro: PREFIX_SEQ_SELF_CHECK_EN.
- When defined:
  - Each capture edge (end of NEG or ADD) compares add_o against an internal behavioural (add_a+add_b) mod 2^W.
  - Adds output out_mismatch (1 bit). It is set with out_valid if either pass of the job mismatched, and cleared with out_valid.
  - Adds output mismatch_cnt (8 bits). It is a saturating count of mismatching jobs, reset to 0.
- When not defined: neither port exists and no comparison logic is built.

Test Plan:
1. Add, SETTLE=2, out_ready=1: in_a=0, in_b=65 -> out_result=65, out_valid high 2 edges after accept for exactly one cycle. Then 100+24 -> 124.
2. Add 0x55+0xAA -> 0xFF. Add 0xFF+0x01 -> 0x00 (wrap, carry dropped).
3. Subtract 100-24 -> 76, valid 4 edges after accept. Subtract 0-1 -> 0xFF. Subtract 0x80-0x80 -> 0x00.
4. Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid and out_result held, in_ready=0 and in_valid ignored. Release -> IDLE, next job accepted on the following edge.
5. Reset mid-operation: assert rst_n low during NEG of a subtract -> outputs immediately at reset values, no result is ever presented. A subsequent job 3+4 -> 7.
6. With PREFIX_SEQ_SELF_CHECK_EN and a bench adder model that forces bit W-1 to 0: 1+0 -> out_result=0, out_mismatch=1, mismatch_cnt=1. A following correct 2+2 -> out_mismatch=0, mismatch_cnt stays 1.
